cnn_conv_stream: RTL and testbench

- Parametrised successor to the monolithic CNN convolution stage.
- Captures one binary image on a start handshake and sweeps a KERNEL_SIZE x KERNEL_SIZE window at a configurable stride.
- Emits all NUM_FEATURES ReLU-and-shift results for one output position per beat, on a valid/ready stream with backpressure.
- Sits between the feature/bias weight memories and the pooling/flatten stages; replaces the fixed-stride, no-handshake convolution loop.

---
 rtl/cnn_pkg.sv | 27 ++
 rtl/cnn_conv_stream_window_mac.sv | 26 ++
 rtl/cnn_conv_stream.sv | 166 ++++++++++++++++
 tb/tb_cnn_conv_stream.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the streaming convolution stage.
// CNN_CONV_SATURATE_EN selects clamping instead of wrap-around on output narrowing.
package cnn_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int COORD_WIDTH = 16;

  function automatic int conv_out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  // ReLU, arithmetic shift, then reduce to dw bits; the caller keeps the low dw bits.
  function automatic logic [63:0] relu_shift_narrow(input logic signed [63:0] psum,
                                                   input int shift, input int dw);
    logic signed [63:0] val;
    if (psum < 0) return '0;
    val = psum >>> shift;
`ifdef CNN_CONV_SATURATE_EN
    if (val > ((64'sd1 <<< (dw - 1)) - 64'sd1)) val = (64'sd1 <<< (dw - 1)) - 64'sd1;
`else
    val = val & ((64'sd1 <<< dw) - 64'sd1);
`endif
    return val;
  endfunction

endpackage

// File: rtl/cnn_conv_stream_window_mac.sv
// Combinational dot product of one binary KxK window against one feature's
// weights, seeded with that feature's bias.
module cnn_window_mac #(
  parameter int KK              = 16,
  parameter int DATA_WIDTH      = 8,
  parameter int PSUM_DATA_WIDTH = 32,
  parameter int BIAS_DATA_WIDTH = 32
) (
  input  logic [KK-1:0]                 win_in,
  input  logic [KK*DATA_WIDTH-1:0]      weights_in,
  input  logic [BIAS_DATA_WIDTH-1:0]    bias_in,
  output logic [PSUM_DATA_WIDTH-1:0]    psum_out
);

  logic signed [PSUM_DATA_WIDTH-1:0] acc;

  always_comb begin
    acc = PSUM_DATA_WIDTH'($signed(bias_in));
    for (int k = 0; k < KK; k++)
      if (win_in[k])
        acc = acc + PSUM_DATA_WIDTH'($signed(weights_in[k*DATA_WIDTH +: DATA_WIDTH]));
  end

  assign psum_out = acc;

endmodule

// File: rtl/cnn_conv_stream.sv
// Streaming KxK binary-image convolution with configurable stride and a
// valid/ready result stream; output narrowing set by CNN_CONV_SATURATE_EN.
module cnn_conv_stream
  import cnn_pkg::*;
#(
  parameter int IMAGE_WIDTH     = 28,
  parameter int IMAGE_HEIGHT    = 28,
  parameter int KERNEL_SIZE     = 4,
  parameter int STRIDE          = 1,
  parameter int NUM_FEATURES    = 3,
  parameter int DATA_WIDTH      = 8,
  parameter int PSUM_DATA_WIDTH = 32,
  parameter int BIAS_DATA_WIDTH = 32,
  parameter int OUT_SHIFT       = 4
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    start,
  input  logic [IMAGE_HEIGHT*IMAGE_WIDTH-1:0]                     image_in,
  input  logic [NUM_FEATURES*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights_in,
  input  logic [NUM_FEATURES*BIAS_DATA_WIDTH-1:0]                 bias_in,
  output logic                                                    busy,
  output logic                                                    out_valid,
  input  logic                                                    out_ready,
  output logic [NUM_FEATURES*DATA_WIDTH-1:0]                      out_data,
  output logic [COORD_WIDTH-1:0]                                  out_row,
  output logic [COORD_WIDTH-1:0]                                  out_col,
  output logic                                                    out_last,
  output logic                                                    done
);

  localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NPIX  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int IDX_W = $clog2(NPIX);
  localparam int OUT_W = conv_out_dim(IMAGE_WIDTH, KERNEL_SIZE, STRIDE);
  localparam int OUT_H = conv_out_dim(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE);
  localparam int CW    = COORD_WIDTH;

  state_e                              state_q, state_d;
  logic [NPIX-1:0]                     img_q, img_d;
  logic [CW-1:0]                       row_q, row_d, col_q, col_d;
  logic                                fin_q, fin_d;
  logic                                out_valid_q, out_valid_d;
  logic                                out_last_q, out_last_d;
  logic [NUM_FEATURES-1:0][DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]                       out_row_q, out_row_d, out_col_q, out_col_d;

  logic [KK-1:0]                               win;
  logic [NUM_FEATURES-1:0][PSUM_DATA_WIDTH-1:0] psum;
  logic [NUM_FEATURES-1:0][DATA_WIDTH-1:0]     res;
  logic [63:0]                                 val;
  logic                                        at_end;

  // Counters never leave the valid output range, so the index stays in the image.
  always_comb begin
    win = '0;
    for (int kr = 0; kr < KERNEL_SIZE; kr++)
      for (int kc = 0; kc < KERNEL_SIZE; kc++)
        win[kr*KERNEL_SIZE + kc] =
          img_q[IDX_W'((int'(row_q)*STRIDE + kr)*IMAGE_WIDTH + int'(col_q)*STRIDE + kc)];
  end

  for (genvar f = 0; f < NUM_FEATURES; f++) begin : g_feat
    cnn_window_mac #(
      .KK              (KK),
      .DATA_WIDTH      (DATA_WIDTH),
      .PSUM_DATA_WIDTH (PSUM_DATA_WIDTH),
      .BIAS_DATA_WIDTH (BIAS_DATA_WIDTH)
    ) u_mac (
      .win_in     (win),
      .weights_in (weights_in[f*KK*DATA_WIDTH +: KK*DATA_WIDTH]),
      .bias_in    (bias_in[f*BIAS_DATA_WIDTH +: BIAS_DATA_WIDTH]),
      .psum_out   (psum[f])
    );
  end

  always_comb begin
    res = '0;
    val = '0;
    for (int f = 0; f < NUM_FEATURES; f++) begin
      val    = relu_shift_narrow(64'($signed(psum[f])), OUT_SHIFT, DATA_WIDTH);
      res[f] = val[DATA_WIDTH-1:0];
    end
  end

  assign at_end = (row_q == CW'(OUT_H - 1)) && (col_q == CW'(OUT_W - 1));

  always_comb begin
    state_d     = state_q;
    img_d       = img_q;
    row_d       = row_q;
    col_d       = col_q;
    fin_d       = fin_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    case (state_q)
      IDLE: if (start) begin
        img_d   = image_in;
        row_d   = '0;
        col_d   = '0;
        fin_d   = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) state_d = DONE;
        end
        // fin_q blocks any load after the final position until the pass ends.
        if (!fin_q && (!out_valid_q || out_ready)) begin
          out_valid_d = 1'b1;
          out_data_d  = res;
          out_row_d   = row_q;
          out_col_d   = col_q;
          out_last_d  = at_end;
          if (at_end) fin_d = 1'b1;
          else if (col_q == CW'(OUT_W - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else col_d = col_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      img_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      fin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      img_q       <= img_d;
      row_q       <= row_d;
      col_q       <= col_d;
      fin_q       <= fin_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;

endmodule

// File: tb/tb_cnn_conv_stream.sv
// Scoreboard bench for cnn_conv_stream: a default-stride instance and a stride-2 instance.
module tb_cnn_conv_stream;
  localparam int W = 28, H = 28, K = 4, NF = 3, DW = 8, KK = K*K;

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
    logic [NF*DW-1:0] data;
    logic last;
  } beat_t;

  typedef struct packed {
    int w0; int w1; int w2;
    int b0; int b1; int b2;
    logic [NF*DW-1:0] exp;
  } vec_t;

  logic clk = 0, rst = 1, start = 0, start2 = 0, out_ready = 1, out_ready2 = 1;
  logic [H*W-1:0] image, saved;
  logic [NF*KK*DW-1:0] weights;
  logic [NF*32-1:0] bias;

  logic o1_busy, o1_valid, o1_last, o1_done;
  logic [NF*DW-1:0] o1_data;
  logic [15:0] o1_row, o1_col;
  logic o2_busy, o2_valid, o2_last, o2_done;
  logic [NF*DW-1:0] o2_data;
  logic [15:0] o2_row, o2_col;

  cnn_conv_stream dut (
    .clk(clk), .rst(rst), .start(start), .image_in(image), .weights_in(weights),
    .bias_in(bias), .busy(o1_busy), .out_valid(o1_valid), .out_ready(out_ready),
    .out_data(o1_data), .out_row(o1_row), .out_col(o1_col), .out_last(o1_last),
    .done(o1_done));

  cnn_conv_stream #(.STRIDE(2)) dut_s2 (
    .clk(clk), .rst(rst), .start(start2), .image_in(image), .weights_in(weights),
    .bias_in(bias), .busy(o2_busy), .out_valid(o2_valid), .out_ready(out_ready2),
    .out_data(o2_data), .out_row(o2_row), .out_col(o2_col), .out_last(o2_last),
    .done(o2_done));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, cyc = 0, acc1 = 0, acc2 = 0, last1 = -10, last2 = -10;
  int wt[NF][KK];
  int bs[NF];
  beat_t q1[$], q2[$];
  beat_t hold;
  logic hold_v = 0;
  bit bp_mode = 0;
  logic [3:0] bp_pat = 4'b1001;
  vec_t tbl[6];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (bp_mode) out_ready = bp_pat[cyc % 4];
  end

  task automatic chk(input bit ok, input string nm, input longint act, input longint req);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic cmp_beat(input string nm, input beat_t a, input beat_t e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got r%0d c%0d d%h l%0d want r%0d c%0d d%h l%0d",
               nm, a.row, a.col, a.data, a.last, e.row, e.col, e.data, e.last);
    end
  endtask

  always @(negedge clk) begin
    beat_t a, e;
    a = '{row: o1_row, col: o1_col, data: o1_data, last: o1_last};
    if (rst) hold_v = 0;
    else begin
      if (hold_v) cmp_beat("stall_hold", a, hold);
      hold_v = o1_valid && !out_ready;
      hold   = a;
      if (o1_valid && out_ready) begin
        if (q1.size() == 0) chk(0, "extra_beat", acc1, -1);
        else begin
          e = q1.pop_front();
          cmp_beat("beat", a, e);
        end
        acc1++;
        if (o1_last) last1 = cyc;
      end
    end
  end

  always @(negedge clk) begin
    beat_t a, e;
    a = '{row: o2_row, col: o2_col, data: o2_data, last: o2_last};
    if (!rst && o2_valid && out_ready2) begin
      if (q2.size() == 0) chk(0, "extra_beat_s2", acc2, -1);
      else begin
        e = q2.pop_front();
        cmp_beat("beat_s2", a, e);
      end
      acc2++;
      if (o2_last) last2 = cyc;
    end
  end

  function automatic logic [NF*DW-1:0] model(input int r, input int c, input int st);
    logic [NF*DW-1:0] d;
    int p, v;
    d = '0;
    for (int f = 0; f < NF; f++) begin
      p = bs[f];
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          if (image[(r*st + kr)*W + c*st + kc]) p += wt[f][kr*K + kc];
      v = (p < 0) ? 0 : (p >>> 4);
`ifdef CNN_CONV_SATURATE_EN
      if (v > 127) v = 127;
`endif
      d[f*DW +: DW] = DW'(v);
    end
    return d;
  endfunction

  task automatic push_exp(input bit use2, input int st, input bit use_const,
                          input logic [NF*DW-1:0] cdat);
    int ow, oh;
    beat_t e;
    ow = (W - K)/st + 1;
    oh = (H - K)/st + 1;
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c++) begin
        e.row  = 16'(r);
        e.col  = 16'(c);
        e.last = (r == oh-1) && (c == ow-1);
        e.data = use_const ? cdat : model(r, c, st);
        if (use2) q2.push_back(e); else q1.push_back(e);
      end
  endtask

  task automatic pack_wb();
    for (int f = 0; f < NF; f++) begin
      for (int k = 0; k < KK; k++) weights[(f*KK + k)*DW +: DW] = DW'(wt[f][k]);
      bias[f*32 +: 32] = 32'(bs[f]);
    end
  endtask

  task automatic load_tbl(input vec_t v);
    for (int k = 0; k < KK; k++) begin
      wt[0][k] = v.w0; wt[1][k] = v.w1; wt[2][k] = v.w2;
    end
    bs[0] = v.b0; bs[1] = v.b1; bs[2] = v.b2;
    pack_wb();
  endtask

  task automatic rand_setup();
    for (int i = 0; i < H*W; i++) image[i] = 1'($urandom_range(0, 1));
    for (int f = 0; f < NF; f++) begin
      for (int k = 0; k < KK; k++) wt[f][k] = int'($urandom_range(0, 15)) - 8;
      bs[f] = int'($urandom_range(0, 100)) - 50;
    end
    pack_wb();
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic start_pass(input bit use2, input bit chk_lat);
    if (use2) start2 = 1; else start = 1;
    @(posedge clk); #1;
    start = 0; start2 = 0;
    if (chk_lat) begin
      @(negedge clk);
      chk(!o1_valid && o1_busy, "latency_c1", {o1_valid, o1_busy}, 2'b01);
      @(negedge clk);
      chk(o1_valid, "latency_c2", o1_valid, 1);
    end
  endtask

  task automatic wait_done(input bit use2, input int nbeats, input int inj_at);
    bit seen, inj, injd;
    seen = 0; inj = 0; injd = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (inj) begin start = 0; image = saved; inj = 0; end
      if (!use2 && inj_at >= 0 && !injd && acc1 >= inj_at) begin
        saved = image; image = ~image; start = 1; inj = 1; injd = 1;
      end
      if (use2 ? o2_done : o1_done) seen = 1;
    end
    chk(seen, "done_seen", seen, 1);
    if (seen) begin
      chk(cyc == (use2 ? last2 : last1) + 1, "done_timing", cyc, (use2 ? last2 : last1) + 1);
      chk((use2 ? acc2 : acc1) == nbeats, "beat_count", use2 ? acc2 : acc1, nbeats);
      chk((use2 ? q2.size() : q1.size()) == 0, "queue_empty", use2 ? q2.size() : q1.size(), 0);
      @(negedge clk);
      chk(!(use2 ? o2_done : o1_done) && !(use2 ? o2_busy : o1_busy), "done_one_cycle",
          use2 ? {o2_done, o2_busy} : {o1_done, o1_busy}, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 1, 1, 0, 0, 0, 24'h010101};
`ifdef CNN_CONV_SATURATE_EN
    tbl[1] = '{127, 127, 127, 4000, 4000, 4000, 24'h7F7F7F};
`else
    tbl[1] = '{127, 127, 127, 4000, 4000, 4000, 24'h797979};
`endif
    tbl[2] = '{-1, 2, 1, 0, 32, 0, 24'h010400};
    tbl[3] = '{1, 1, 1, -20, -16, 15, 24'h010000};
    tbl[4] = '{0, 0, -3, 100, 255, 2000, 24'h7A0F06};
    tbl[5] = '{8, -8, 127, 0, 0, 0, 24'h7F0008};

    image = '0; weights = '0; bias = '0;
    repeat (3) @(negedge clk);
    chk(!o1_busy && !o1_valid && !o1_last && !o1_done && o1_data == 0 && o1_row == 0 && o1_col == 0,
        "reset_state", {o1_busy, o1_valid, o1_last, o1_done, o1_row, o1_col}, 0);
    rst = 0;
    @(negedge clk);

    // Uniform-weight vectors on an all-ones image.
    for (int i = 0; i < 6; i++) begin
      image = '1;
      load_tbl(tbl[i]);
      push_exp(0, 1, 1, tbl[i].exp);
      acc1 = 0;
      start_pass(0, i == 0);
      wait_done(0, 625, -1);
    end

    // Stride 2: uniform vector then a random image.
    image = '1;
    load_tbl(tbl[2]);
    push_exp(1, 2, 1, tbl[2].exp);
    acc2 = 0;
    start_pass(1, 0);
    wait_done(1, 169, -1);
    rand_setup();
    push_exp(1, 2, 0, '0);
    acc2 = 0;
    start_pass(1, 0);
    wait_done(1, 169, -1);

    // Backpressure with ready pattern 1,0,0,1.
    rand_setup();
    push_exp(0, 1, 0, '0);
    acc1 = 0;
    bp_mode = 1;
    start_pass(0, 0);
    wait_done(0, 625, -1);
    bp_mode = 0;
    out_ready = 1;
    @(negedge clk);

    // Start while busy is ignored; then a start right as IDLE is re-entered.
    rand_setup();
    push_exp(0, 1, 0, '0);
    acc1 = 0;
    start_pass(0, 0);
    wait_done(0, 625, 100);
    rand_setup();
    push_exp(0, 1, 0, '0);
    acc1 = 0;
    start_pass(0, 1);
    wait_done(0, 625, -1);

    // Reset mid-pass.
    rand_setup();
    push_exp(0, 1, 0, '0);
    acc1 = 0;
    start_pass(0, 0);
    for (int i = 0; i < 200 && acc1 < 37; i++) @(negedge clk);
    chk(acc1 >= 37, "reach_beat37", acc1, 37);
    rst = 1;
    @(negedge clk);
    chk(!o1_valid && !o1_busy && o1_row == 0 && o1_col == 0 && !o1_done,
        "mid_reset", {o1_valid, o1_busy, o1_done, o1_row, o1_col}, 0);
    begin
      bit any_done;
      any_done = 0;
      repeat (3) begin
        @(negedge clk);
        if (o1_done) any_done = 1;
      end
      chk(!any_done, "no_done_after_reset", any_done, 0);
    end
    q1.delete();
    rst = 0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
